s2_demux: RTL and testbench
===========================

// Module: s2_demux
// PURPOSE
//  Registered 1-to-4 demultiplexer; the distribution-side counterpart of the S2 registered 4:1 select module.
//  One N-bit input word is steered to one of four output registers.
//  The register is chosen by the S2 select function: S1 = A1|B1, S0 = A0&B0.
//  Each output register has a valid/ready handshake.
//  The block sits between one producer and up to four consumers in the logic-module datapath.
// PARAMETERS
//  N      1  data width of din and Q0..Q3
//  CNT_W  8  width of the delivered-word counter xfer_cnt
// PORTS
//  clk       in   1      clock; all state changes on posedge
//  clr       in   1      synchronous reset, active-low (0 = reset)
//  din       in   N      input data word
//  in_valid  in   1      din and A1/B1/A0/B0 are valid this cycle
//  in_ready  out  1      block can accept din this cycle
//  A1,B1     in   1      select inputs; S1 = A1|B1
//  A0,B0     in   1      select inputs; S0 = A0&B0
//  Q0..Q3    out  N      output data registers, channels 0..3
//  q_valid   out  4      bit k: Qk holds an undelivered word
//  q_ready   in   4      bit k: consumer k accepts Qk this cycle
//  xfer_cnt  out  CNT_W  running count of output handshakes
// BEHAVIOUR
//  Channel select:
//   - sel = {S1,S0}: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
//   - sel is purely combinational from the current A1/B1/A0/B0.
//  Input readiness:
//   - in_ready = clr & (~q_valid[sel] | q_ready[sel]).
//   - in_ready depends only on the selected channel; a full channel blocks input even if others are empty.
//  Accept:
//   - An accept occurs when in_valid & in_ready at a posedge.
//   - On accept: Q[sel] <= din and q_valid[sel] <= 1.
//   - Latency is 1 cycle: the word is visible on Q[sel] with q_valid[sel]=1 in the cycle after acceptance.
//  Output handshake per channel k:
//   - A handshake occurs when q_valid[k] & q_ready[k].
//   - On handshake without a reload of k: q_valid[k] <= 0.
//   - Qk keeps its last value after drain; it is not cleared.
//  Simultaneous drain and load on the same channel:
//   - Load wins: Qk <= din and q_valid[k] stays 1.
//   - This permits full throughput of 1 word per cycle into a single channel.
//  Hold and independence:
//   - While q_valid[k]=1 and q_ready[k]=0, Qk is held stable.
//   - Channels are independent: loading channel j never alters Qk or q_valid[k] for k != j.
//  xfer_cnt:
//   - Incremented each cycle by popcount(q_valid & q_ready), range 0..4.
//   - Wraps modulo 2^CNT_W.
//   - Input accepts are not counted.
//  Reset (clr=0 at posedge):
//   - Q0..Q3 = 0, q_valid = 4'b0000, xfer_cnt = 0.
//   - in_ready = 0 for the whole cycle clr is low.
//  Reset mid-operation:
//   - Undelivered words are discarded and no handshake is counted.
//   - Operation resumes on the first posedge with clr=1.
//  Outside an accept, in_valid=0 or unknown select inputs have no effect on state.
// TESTING
//  1. Reset: hold clr=0 with in_valid=1, din=1
//     -> Q*=0, q_valid=0000, in_ready=0, xfer_cnt=0.
//  2. Routing, N=4: send din=A with A1=0,B1=0,A0=1,B0=1 (sel 01), q_ready=0
//     -> next cycle Q1=A, q_valid=0010, Q0/Q2/Q3 unchanged.
//     Then sel 10 with din=5 -> Q2=5, q_valid=0110.
//  3. Backpressure: ch1 full, q_ready=0000, in_valid=1 with sel 01
//     -> in_ready=0 and Q1 held at A.
//     Switch to sel 00 -> in_ready=1; the word lands in Q0.
//  4. Same-cycle drain+load: ch3 valid=3, q_ready[3]=1, in_valid=1, din=9, sel 11
//     -> next cycle Q3=9, q_valid[3]=1, xfer_cnt +1.
//  5. Multi-drain and wrap: CNT_W=2, xfer_cnt=3, all four channels valid, q_ready=1111
//     -> xfer_cnt=3 (3+4 mod 4), q_valid=0000.
//  6. Reset mid-stream: channels 0 and 2 valid, clr=0 for one cycle
//     -> q_valid=0000, Q*=0, xfer_cnt=0.
//     Next accept of din=6 on sel 00 -> Q0=6 one cycle later.

Source files
------------

// File: rtl/s2_demux.sv
// rtl/s2_demux.sv - registered 1-to-4 demultiplexer with S2 select and per-channel valid/ready
module s2_demux #(
  parameter int N     = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [N-1:0]     i_din,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_a1,
  input  logic             i_b1,
  input  logic             i_a0,
  input  logic             i_b0,
  output logic [N-1:0]     o_q0,
  output logic [N-1:0]     o_q1,
  output logic [N-1:0]     o_q2,
  output logic [N-1:0]     o_q3,
  output logic [3:0]       o_q_valid,
  input  logic [3:0]       i_q_ready,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  logic [1:0]       w_sel;
  logic             w_accept;
  logic [3:0]       w_hs;
  logic [2:0]       w_hs_cnt;
  logic [N-1:0]     r_q [4];
  logic [3:0]       r_q_valid;
  logic [CNT_W-1:0] r_xfer_cnt;

  // Select decode, input readiness and per-channel handshake detection
  always_comb begin
    w_sel      = {i_a1 | i_b1, i_a0 & i_b0};
    o_in_ready = i_clr & (~r_q_valid[w_sel] | i_q_ready[w_sel]);
    w_accept   = i_in_valid & o_in_ready;
    w_hs       = r_q_valid & i_q_ready;
    w_hs_cnt   = {2'b00, w_hs[0]} + {2'b00, w_hs[1]} + {2'b00, w_hs[2]} + {2'b00, w_hs[3]};
  end

  // Channel registers: a load into a channel wins over its same-cycle drain
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      for (int k = 0; k < 4; k++) begin
        r_q[k] <= '0;
      end
      r_q_valid  <= 4'b0000;
      r_xfer_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (w_sel == 2'(k))) begin
          r_q[k]       <= i_din;
          r_q_valid[k] <= 1'b1;
        end else if (w_hs[k]) begin
          r_q_valid[k] <= 1'b0;
        end
      end
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(w_hs_cnt);
    end
  end

  assign o_q0       = r_q[0];
  assign o_q1       = r_q[1];
  assign o_q2       = r_q[2];
  assign o_q3       = r_q[3];
  assign o_q_valid  = r_q_valid;
  assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_s2_demux.sv
// tb/tb_s2_demux.sv - vector table and random model check for s2_demux
module tb_s2_demux;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             clr;
  logic [N-1:0]     din;
  logic             in_valid;
  logic             in_ready;
  logic             a1, b1, a0, b0;
  logic [N-1:0]     q0, q1, q2, q3;
  logic [3:0]       q_valid;
  logic [3:0]       q_ready;
  logic [CNT_W-1:0] xfer_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  s2_demux #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_clr(clr), .i_din(din), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a1(a1), .i_b1(b1), .i_a0(a0), .i_b0(b0),
    .o_q0(q0), .o_q1(q1), .o_q2(q2), .o_q3(q3),
    .o_q_valid(q_valid), .i_q_ready(q_ready), .o_xfer_cnt(xfer_cnt)
  );

  typedef struct {
    logic       clr;
    logic [3:0] din;
    logic       iv;
    logic [3:0] sbits;   // {A1,B1,A0,B0}
    logic [3:0] qr;
    logic       rdy;     // expected in_ready before the edge
    logic [3:0] vld;     // expected state after the edge
    logic [3:0] eq0, eq1, eq2, eq3;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl [17];

  // behavioural model state
  logic [3:0] mq [4];
  logic [3:0] mv;
  int         mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic [3:0] d, input logic v,
                       input logic [3:0] s, input logic [3:0] r);
    clr = c; din = d; in_valid = v;
    {a1, b1, a0, b0} = s;
    q_ready = r;
  endtask

  task automatic model_step(output logic exp_rdy);
    int sel;
    sel = ((a1 | b1) ? 2 : 0) + ((a0 & b0) ? 1 : 0);
    exp_rdy = clr && (!mv[sel] || q_ready[sel]);
    if (!clr) begin
      for (int k = 0; k < 4; k++) mq[k] = 4'h0;
      mv = 4'b0000;
      mcnt = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mv[k] && q_ready[k]) begin
          mcnt++;
          mv[k] = 1'b0;
        end
      end
      if (in_valid && exp_rdy) begin
        mq[sel] = din;
        mv[sel] = 1'b1;
      end
    end
  endtask

  initial begin
    logic r_exp;
    //            clr   din   iv    sbits    qr       rdy   vld      Q0    Q1    Q2    Q3    cnt
    tbl[0]  = '{1'b0, 4'h1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
    tbl[1]  = '{1'b0, 4'h1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
    tbl[2]  = '{1'b1, 4'hA, 1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0010, 4'h0, 4'hA, 4'h0, 4'h0, 2'd0};
    tbl[3]  = '{1'b1, 4'h5, 1'b1, 4'b1000, 4'b0000, 1'b1, 4'b0110, 4'h0, 4'hA, 4'h5, 4'h0, 2'd0};
    tbl[4]  = '{1'b1, 4'h7, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0110, 4'h0, 4'hA, 4'h5, 4'h0, 2'd0};
    tbl[5]  = '{1'b1, 4'h7, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0111, 4'h7, 4'hA, 4'h5, 4'h0, 2'd0};
    tbl[6]  = '{1'b1, 4'h3, 1'b1, 4'b1011, 4'b0000, 1'b1, 4'b1111, 4'h7, 4'hA, 4'h5, 4'h3, 2'd0};
    tbl[7]  = '{1'b1, 4'h9, 1'b1, 4'b1011, 4'b1000, 1'b1, 4'b1111, 4'h7, 4'hA, 4'h5, 4'h9, 2'd1};
    tbl[8]  = '{1'b1, 4'h2, 1'b1, 4'b0111, 4'b1000, 1'b1, 4'b1111, 4'h7, 4'hA, 4'h5, 4'h2, 2'd2};
    tbl[9]  = '{1'b1, 4'h4, 1'b1, 4'b1011, 4'b1000, 1'b1, 4'b1111, 4'h7, 4'hA, 4'h5, 4'h4, 2'd3};
    tbl[10] = '{1'b1, 4'hE, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'h7, 4'hA, 4'h5, 4'h4, 2'd3};
    tbl[11] = '{1'b1, 4'hB, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'hB, 4'hA, 4'h5, 4'h4, 2'd3};
    tbl[12] = '{1'b1, 4'hC, 1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0101, 4'hB, 4'hA, 4'hC, 4'h4, 2'd3};
    tbl[13] = '{1'b0, 4'hF, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
    tbl[14] = '{1'b1, 4'h6, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'h6, 4'h0, 4'h0, 4'h0, 2'd0};
    tbl[15] = '{1'b1, 4'h8, 1'b1, 4'b0011, 4'b0001, 1'b1, 4'b0010, 4'h6, 4'h8, 4'h0, 4'h0, 2'd1};
    tbl[16] = '{1'b1, 4'hD, 1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0010, 4'h6, 4'h8, 4'h0, 4'h0, 2'd1};

    drive(1'b0, 4'h0, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].clr, tbl[i].din, tbl[i].iv, tbl[i].sbits, tbl[i].qr);
      #1;
      chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d q_valid", i), 32'(q_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d q0", i), 32'(q0), 32'(tbl[i].eq0));
      chk($sformatf("tbl%0d q1", i), 32'(q1), 32'(tbl[i].eq1));
      chk($sformatf("tbl%0d q2", i), 32'(q2), 32'(tbl[i].eq2));
      chk($sformatf("tbl%0d q3", i), 32'(q3), 32'(tbl[i].eq3));
      chk($sformatf("tbl%0d xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].cnt));
      @(negedge clk);
    end

    // randomized run against the reference model, starting from reset
    for (int k = 0; k < 4; k++) mq[k] = 4'h0;
    mv = 4'b0000;
    mcnt = 0;
    for (int i = 0; i < 2000; i++) begin
      drive((i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0),
            4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      #1;
      model_step(r_exp);
      chk("rnd in_ready", 32'(in_ready), 32'(r_exp));
      @(posedge clk);
      #1;
      chk("rnd q_valid", 32'(q_valid), 32'(mv));
      chk("rnd q0", 32'(q0), 32'(mq[0]));
      chk("rnd q1", 32'(q1), 32'(mq[1]));
      chk("rnd q2", 32'(q2), 32'(mq[2]));
      chk("rnd q3", 32'(q3), 32'(mq[3]));
      chk("rnd xfer_cnt", 32'(xfer_cnt), 32'(mcnt % (1 << CNT_W)));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
